dice_roller: RTL

Downstream consumer of the 8-bit LFSR/shift-register stage (mode 5). Takes the free-running pseudo-random byte and a raw push-button, and on each debounced press runs a short "rolling" animation. The animation draws faces 1..6 from the random byte by rejection sampling, then settles on a final face. Drives two active-low 7-segment digits: the current face, and a 4-bit count of completed rolls in hex.

---
 rtl/dice_roller_if.sv | 33 +++
 rtl/dice_roller.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dice_roller_if.sv
`default_nettype none
// ============================================================================
//  Module      : dice_roller_if
//  Description : Signal bundle between the dice roller and its environment:
//                enable, raw key, random byte in; face, status, counter and
//                two 7-segment digits out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dice_roller_if;
    logic       en;
    logic       key;
    // Random byte from the LFSR stage ("rand" itself is a reserved word).
    logic [7:0] rand_byte;
    logic [2:0] face;
    logic       busy;
    logic       done;
    logic [3:0] rolls;
    logic [6:0] seg0;
    logic [6:0] seg1;

    // Environment side: drives the inputs, observes the display outputs.
    modport master (
        output en, key, rand_byte,
        input  face, busy, done, rolls, seg0, seg1
    );

    // Roller side.
    modport slave (
        input  en, key, rand_byte,
        output face, busy, done, rolls, seg0, seg1
    );
endinterface
`default_nettype wire

// File: rtl/dice_roller.sv
`default_nettype none
// ============================================================================
//  Module      : dice_roller
//  Description : Debounced push-button dice. Each accepted press runs a
//                rolling animation that draws faces 1..6 from the random byte
//                by rejection sampling, then shows the final face and bumps
//                a 4-bit roll counter. Both values drive active-low 7-segment
//                digits.
//  Revision    : 1.0 - initial release
// ============================================================================
module dice_roller #(
    parameter int DEB_CYCLES  = 16,
    parameter int TICK_CYCLES = 4,
    parameter int ROLL_STEPS  = 8
) (
    input  logic          clk,
    input  logic          rst,
    dice_roller_if.slave  bus
);

    localparam int c_DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int c_TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int c_STEP_W = (ROLL_STEPS > 1) ? $clog2(ROLL_STEPS) : 1;

    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(ROLL_STEPS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ROLL = 2'd1;
    localparam logic [1:0] c_ST_SHOW = 2'd2;

    logic                r_key_meta;
    logic                r_key_s;
    logic [c_DEB_W-1:0]  r_deb_cnt;
    logic                r_key_stable;
    logic                r_key_stable_d;
    logic                w_press;

    logic [1:0]          r_state;
    logic [c_TICK_W-1:0] r_tick;
    logic [c_STEP_W-1:0] r_step;
    logic [2:0]          r_face;
    logic                r_busy;
    logic                r_done;
    logic [3:0]          r_rolls;

    logic [2:0]          w_sample;
    logic                w_accept;
    logic                w_unused;

    // Hex digit to active-low {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] f_hex7(input logic [3:0] v);
        case (v)
            4'h0:    f_hex7 = 7'b1000000;
            4'h1:    f_hex7 = 7'b1111001;
            4'h2:    f_hex7 = 7'b0100100;
            4'h3:    f_hex7 = 7'b0110000;
            4'h4:    f_hex7 = 7'b0011001;
            4'h5:    f_hex7 = 7'b0010010;
            4'h6:    f_hex7 = 7'b0000010;
            4'h7:    f_hex7 = 7'b1111000;
            4'h8:    f_hex7 = 7'b0000000;
            4'h9:    f_hex7 = 7'b0010000;
            4'hA:    f_hex7 = 7'b0001000;
            4'hB:    f_hex7 = 7'b0000011;
            4'hC:    f_hex7 = 7'b1000110;
            4'hD:    f_hex7 = 7'b0100001;
            4'hE:    f_hex7 = 7'b0000110;
            default: f_hex7 = 7'b0001110;
        endcase
    endfunction

    // Two-flop synchronizer for the asynchronous key level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_meta <= 1'b0;
            r_key_s    <= 1'b0;
        end else begin
            r_key_meta <= bus.key;
            r_key_s    <= r_key_meta;
        end
    end

    // Debounce: accept a new level after DEB_CYCLES consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_cnt      <= '0;
            r_key_stable   <= 1'b0;
            r_key_stable_d <= 1'b0;
        end else begin
            r_key_stable_d <= r_key_stable;
            if (r_key_s == r_key_stable) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == c_DEB_LAST) begin
                r_key_stable <= r_key_s;
                r_deb_cnt    <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    assign w_press  = r_key_stable & ~r_key_stable_d;

    // Only the low three bits form a candidate face; 0 and 7 are rejected.
    assign w_sample = bus.rand_byte[2:0];
    assign w_accept = (w_sample != 3'd0) && (w_sample != 3'd7);
    assign w_unused = &{1'b0, bus.rand_byte[7:3]};

    // Roll sequencer: IDLE -> ROLL (sample every TICK_CYCLES) -> SHOW -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_tick  <= '0;
            r_step  <= '0;
            r_face  <= 3'd1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rolls <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_tick <= '0;
                    r_step <= '0;
                    if (w_press && bus.en) begin
                        r_state <= c_ST_ROLL;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_ROLL: begin
                    if (!bus.en) begin
                        // Abort keeps the last accepted face and does not count.
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_tick == c_TICK_LAST) begin
                        r_tick <= '0;
                        if (w_accept) begin
                            r_face <= w_sample;
                            if (r_step == c_STEP_LAST) begin
                                r_state <= c_ST_SHOW;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_rolls <= r_rolls + 4'd1;
                            end else begin
                                r_step <= r_step + 1'b1;
                            end
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                c_ST_SHOW: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.face  = r_face;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.rolls = r_rolls;
    assign bus.seg0  = f_hex7({1'b0, r_face});
    assign bus.seg1  = f_hex7(r_rolls);

endmodule
`default_nettype wire
